// File: rtl/ddr_rw_arbiter.sv
// Read/write command arbiter: queues read and write requests and batches them to the DDR sequencer.
// Latency: an entry pushed in cycle t can be presented on cmd_* no earlier than cycle t+1.
// Backpressure: x_ready drops when that queue is full; cmd_* holds steady while cmd_ready is low.
module ddr_rw_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MAX_BATCH = 4,
  parameter int TURN_R2W  = 2,
  parameter int TURN_W2R  = 4
) (
  input  logic                         clock_t,
  input  logic                         reset,
  input  logic                         rd_valid,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_ready,
  input  logic                         wr_valid,
  input  logic [ADDR_W-1:0]            wr_addr,
  output logic                         wr_ready,
  output logic                         cmd_valid,
  output logic [1:0]                   cmd_rw,
  output logic [ADDR_W-1:0]            cmd_addr,
  input  logic                         cmd_ready,
  output logic [$clog2(DEPTH+1)-1:0]   rd_count,
  output logic [$clog2(DEPTH+1)-1:0]   wr_count,
  output logic                         busy
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW   = $clog2(MAX_BATCH + 1);
  localparam int TMAX = (TURN_R2W > TURN_W2R) ? TURN_R2W : TURN_W2R;
  localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [BW-1:0] BATCH_MAX = BW'(MAX_BATCH);
  localparam logic [TW-1:0] LEN_R2W   = TW'(TURN_R2W);
  localparam logic [TW-1:0] LEN_W2R   = TW'(TURN_W2R);

  // Direction encoding: 0 = read, 1 = write.
  localparam logic DIR_RD = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2,
    ARB_TURN  = 2'd3
  } arb_state_t;

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [BW-1:0]       r_batch;
  logic [TW-1:0]       r_turn_left;
  logic                r_turn_dir;
  logic                r_last_dir;
  logic                r_first_done;

  logic [ADDR_W-1:0]   r_rd_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_mem [DEPTH];
  logic [PW-1:0]       r_rd_wptr, r_rd_rptr, r_wr_wptr, r_wr_rptr;
  logic [CW-1:0]       r_rd_count, r_wr_count;

  logic                w_rd_push, w_wr_push, w_issue, w_rd_pop, w_wr_pop;
  logic [CW-1:0]       w_rd_cnt_nxt, w_wr_cnt_nxt;
  logic                w_rd_ne, w_wr_ne;
  logic [BW-1:0]       w_batch_inc;
  logic                w_batch_clr, w_turn_load, w_turn_dir_nxt;
  logic [TW-1:0]       w_turn_len;
  logic                w_enter, w_enter_dir, w_enter_turn;
  logic                w_cur_ne, w_opp_ne;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on occupancy, so a same-cycle pop never frees a slot early.
  assign rd_ready  = !reset && (r_rd_count < DEPTH_C);
  assign wr_ready  = !reset && (r_wr_count < DEPTH_C);
  assign w_rd_push = rd_valid && rd_ready;
  assign w_wr_push = wr_valid && wr_ready;

  assign cmd_valid = !reset && (((r_state == ARB_READ)  && (r_rd_count != '0)) ||
                                ((r_state == ARB_WRITE) && (r_wr_count != '0)));
  assign cmd_rw    = !cmd_valid ? 2'b00 : ((r_state == ARB_WRITE) ? 2'b10 : 2'b01);
  assign cmd_addr  = !cmd_valid ? '0 :
                     ((r_state == ARB_WRITE) ? r_wr_mem[r_wr_rptr] : r_rd_mem[r_rd_rptr]);

  assign w_issue  = cmd_valid && cmd_ready;
  assign w_rd_pop = w_issue && (r_state == ARB_READ);
  assign w_wr_pop = w_issue && (r_state == ARB_WRITE);

  // Arbitration looks at occupancy after this cycle's pushes and pops so streams run back-to-back.
  assign w_rd_cnt_nxt = r_rd_count + CW'(w_rd_push) - CW'(w_rd_pop);
  assign w_wr_cnt_nxt = r_wr_count + CW'(w_wr_push) - CW'(w_wr_pop);
  assign w_rd_ne      = (w_rd_cnt_nxt != '0);
  assign w_wr_ne      = (w_wr_cnt_nxt != '0);
  assign w_batch_inc  = r_batch + BW'(w_issue);

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
  assign busy     = !reset && ((r_state != ARB_IDLE) || (r_rd_count != '0) || (r_wr_count != '0));

  // Queue storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock_t) begin
    if (w_rd_push) r_rd_mem[r_rd_wptr] <= rd_addr;
    if (w_wr_push) r_wr_mem[r_wr_wptr] <= wr_addr;
  end

  // Circular queue pointers and occupancy counters.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      r_rd_wptr  <= '0;
      r_rd_rptr  <= '0;
      r_wr_wptr  <= '0;
      r_wr_rptr  <= '0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_rd_count <= w_rd_cnt_nxt;
      r_wr_count <= w_wr_cnt_nxt;
      if (w_rd_push) r_rd_wptr <= ptr_inc(r_rd_wptr);
      if (w_rd_pop)  r_rd_rptr <= ptr_inc(r_rd_rptr);
      if (w_wr_push) r_wr_wptr <= ptr_inc(r_wr_wptr);
      if (w_wr_pop)  r_wr_rptr <= ptr_inc(r_wr_rptr);
    end
  end

  // Next-state: pick a direction, bound batches, and route direction changes through the turnaround.
  always_comb begin
    w_state_nxt    = r_state;
    w_batch_clr    = 1'b0;
    w_turn_load    = 1'b0;
    w_turn_dir_nxt = r_turn_dir;
    w_enter        = 1'b0;
    w_enter_dir    = r_last_dir;
    w_enter_turn   = 1'b0;
    w_cur_ne       = (r_state == ARB_WRITE) ? w_wr_ne : w_rd_ne;
    w_opp_ne       = (r_state == ARB_WRITE) ? w_rd_ne : w_wr_ne;

    case (r_state)
      ARB_IDLE: begin
        if (w_rd_ne || w_wr_ne) begin
          w_enter      = 1'b1;
          w_enter_dir  = (w_rd_ne && w_wr_ne) ? r_last_dir : w_wr_ne;
          w_enter_turn = r_first_done && (w_enter_dir != r_last_dir);
        end
      end
      ARB_READ, ARB_WRITE: begin
        if (!w_rd_ne && !w_wr_ne) begin
          w_state_nxt = ARB_IDLE;
        end else if (!w_cur_ne || ((w_batch_inc == BATCH_MAX) && w_opp_ne)) begin
          w_enter      = 1'b1;
          w_enter_dir  = (r_state == ARB_READ);
          w_enter_turn = 1'b1;
        end else if (w_batch_inc == BATCH_MAX) begin
          // Nothing waiting the other way: start a fresh batch in place.
          w_batch_clr = 1'b1;
        end
      end
      ARB_TURN: begin
        if (r_turn_left <= TW'(1)) begin
          w_state_nxt = r_turn_dir ? ARB_WRITE : ARB_READ;
          w_batch_clr = 1'b1;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase

    // Entering write means leaving read, so the read-to-write gap applies, and vice versa.
    w_turn_len = w_enter_dir ? LEN_R2W : LEN_W2R;
    if (w_enter) begin
      if (w_enter_turn && (w_turn_len != '0)) begin
        w_state_nxt    = ARB_TURN;
        w_turn_load    = 1'b1;
        w_turn_dir_nxt = w_enter_dir;
      end else begin
        w_state_nxt = w_enter_dir ? ARB_WRITE : ARB_READ;
        w_batch_clr = 1'b1;
      end
    end
  end

  // State register, batch and turnaround counters, and last-issue direction tracking.
  always_ff @(posedge clock_t) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_batch      <= '0;
      r_turn_left  <= '0;
      r_turn_dir   <= DIR_RD;
      r_last_dir   <= DIR_RD;
      r_first_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_batch <= w_batch_clr ? '0 : w_batch_inc;
      if (w_turn_load) begin
        r_turn_left <= w_turn_len;
        r_turn_dir  <= w_turn_dir_nxt;
      end else if (r_state == ARB_TURN) begin
        r_turn_left <= r_turn_left - TW'(1);
      end
      if (w_issue) begin
        r_last_dir   <= (r_state == ARB_WRITE);
        r_first_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Scoreboard bench for ddr_rw_arbiter: expected issues (direction, address, cycle) queued with stimulus.
// Latency: each expected issue carries the exact cycle it must appear in.
// Backpressure: cmd_ready and queue-full behaviour are exercised directly.
module tb_ddr_rw_arbiter;

  localparam int AW = 32;
  localparam logic [1:0] RW_RD = 2'b01;
  localparam logic [1:0] RW_WR = 2'b10;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_valid, wr_valid, rd_ready, wr_ready;
  logic [AW-1:0] rd_addr, wr_addr, cmd_addr;
  logic          cmd_valid, cmd_ready, busy;
  logic [1:0]    cmd_rw;
  logic [2:0]    rd_count, wr_count;

  typedef struct {
    logic [1:0]    rw;
    logic [AW-1:0] addr;
    int            cyc;
  } iss_t;

  iss_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   c0;

  ddr_rw_arbiter dut (
    .clock_t   (clk),
    .reset     (reset),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_ready  (rd_ready),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_ready  (wr_ready),
    .cmd_valid (cmd_valid),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_ready (cmd_ready),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_iss(input logic [1:0] rw, input logic [AW-1:0] addr, input int c);
    iss_t e;
    e.rw   = rw;
    e.addr = addr;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Issue monitor: every accepted command must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue", 64'(cmd_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        iss_t e;
        e = sb.pop_front();
        chk("iss_rw", 64'(cmd_rw), 64'(e.rw));
        chk("iss_addr", 64'(cmd_addr), 64'(e.addr));
        chk("iss_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_cmd_rw"}, 64'(cmd_rw), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rd_count"}, 64'(rd_count), 64'd0);
    chk({tag, "_wr_count"}, 64'(wr_count), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    rd_valid  = 1'b0;
    wr_valid  = 1'b0;
    rd_addr   = '0;
    wr_addr   = '0;
    cmd_ready = 1'b0;

    // Reset values, then release and idle.
    repeat (3) tick();
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rel_rd_ready", 64'(rd_ready), 64'd1);
    chk("rel_wr_ready", 64'(wr_ready), 64'd1);
    repeat (4) tick();
    @(negedge clk);
    chk_quiet("idle");
    chk("idle_rd_ready", 64'(rd_ready), 64'd1);
    chk("idle_wr_ready", 64'(wr_ready), 64'd1);

    // Three back-to-back reads: issues on the three cycles after each push.
    cmd_ready = 1'b1;
    tick();
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      rd_valid = 1'b1;
      rd_addr  = 32'h100 + i;
      expect_iss(RW_RD, 32'h100 + i, c0 + 1 + i);
    end
    tick();
    rd_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk_quiet("s3r");
    chk("s3r_sb_empty", 64'(sb.size()), 64'd0);

    // Six reads and one write: 4 R, 2-cycle gap, W, 4-cycle gap, 2 R.
    tick();
    c0 = cyc;
    for (int i = 0; i < 4; i++) expect_iss(RW_RD, 32'h200 + i, c0 + 1 + i);
    expect_iss(RW_WR, 32'h900, c0 + 7);
    expect_iss(RW_RD, 32'h204, c0 + 12);
    expect_iss(RW_RD, 32'h205, c0 + 13);
    wr_valid = 1'b1;
    wr_addr  = 32'h900;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      if (i == 1) wr_valid = 1'b0;
      rd_valid = 1'b1;
      rd_addr  = 32'h200 + i;
    end
    tick();
    rd_valid = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk_quiet("batch");
    chk("batch_sb_empty", 64'(sb.size()), 64'd0);

    // Five reads against a stalled sequencer: fifth waits for the first pop.
    cmd_ready = 1'b0;
    tick();
    c0 = cyc;
    for (int i = 0; i < 5; i++) expect_iss(RW_RD, 32'h300 + i, c0 + 5 + i);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      rd_valid = 1'b1;
      rd_addr  = 32'h300 + i;
      @(negedge clk);
      chk($sformatf("full_rd_ready%0d", i), 64'(rd_ready), (i < 4) ? 64'd1 : 64'd0);
    end
    chk("full_rd_count", 64'(rd_count), 64'd4);
    tick();
    cmd_ready = 1'b1;
    @(negedge clk);
    chk("full_ready_at_first_issue", 64'(rd_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("full_ready_after_issue", 64'(rd_ready), 64'd1);
    tick();
    rd_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk_quiet("full");
    chk("full_sb_empty", 64'(sb.size()), 64'd0);

    // Write after reads: 2-cycle turn, then command held stable while stalled.
    cmd_ready = 1'b0;
    tick();
    c0 = cyc;
    expect_iss(RW_WR, 32'hA5A5_0001, c0 + 6);
    wr_valid = 1'b1;
    wr_addr  = 32'hA5A5_0001;
    tick();
    wr_valid = 1'b0;
    wr_addr  = '0;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      if (i < 3) begin
        chk($sformatf("stall_turn_valid%0d", i), 64'(cmd_valid), 64'd0);
        chk($sformatf("stall_turn_busy%0d", i), 64'(busy), 64'd1);
      end else begin
        chk($sformatf("stall_valid%0d", i), 64'(cmd_valid), 64'd1);
        chk($sformatf("stall_rw%0d", i), 64'(cmd_rw), 64'(RW_WR));
        chk($sformatf("stall_addr%0d", i), 64'(cmd_addr), 64'hA5A5_0001);
        chk($sformatf("stall_wr_count%0d", i), 64'(wr_count), 64'd1);
      end
      tick();
    end
    cmd_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk_quiet("stall");
    chk("stall_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the second cycle of a write-to-read turn discards the queued reads.
    tick();
    rd_valid = 1'b1;
    rd_addr  = 32'h400;
    tick();
    rd_addr  = 32'h401;
    tick();
    rd_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("mid_rst_rd_ready", 64'(rd_ready), 64'd0);
    chk("mid_rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("mid_rst_cmd_valid", 64'(cmd_valid), 64'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("post_rst");
    repeat (8) tick();
    @(negedge clk);
    chk_quiet("post_rst_late");
    chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ddr_rw_arbiter.md
DDR_RW_ARBITER -- requirements
Module: ddr_rw_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising clock_t edge only.
REQ-002 Parameter ADDR_W, default 32, SHALL set the request address width.
REQ-003 Parameter DEPTH, default 4, SHALL set the entries in each of the read and write FIFOs.
REQ-004 Parameter MAX_BATCH, default 4, SHALL set the maximum same-direction issues before a forced switch.
REQ-005 Parameter TURN_R2W, default 2, SHALL set the idle cycles for a read-to-write turnaround.
REQ-006 Parameter TURN_W2R, default 4, SHALL set the idle cycles for a write-to-read turnaround.
REQ-007 clock_t  in  1  SHALL be the system clock.
REQ-008 reset  in  1  SHALL be the synchronous active-high reset.
REQ-009 rd_valid/rd_addr/rd_ready  in/in/out  1/ADDR_W/1  SHALL be the read request push handshake.
REQ-010 wr_valid/wr_addr/wr_ready  in/in/out  1/ADDR_W/1  SHALL be the write request push handshake.
REQ-011 cmd_valid/cmd_rw/cmd_addr  out/out/out  1/2/ADDR_W  SHALL be the command to the ACT/CAS sequencer, with cmd_rw READ=2'b01, WRITE=2'b10, and 2'b00 whenever cmd_valid=0.
REQ-012 cmd_ready  in  1  SHALL be the sequencer acceptance signal.
REQ-013 rd_count/wr_count  out  $clog2(DEPTH+1)  SHALL report FIFO occupancy.
REQ-014 busy  out  1  SHALL be high whenever the state is not ARB_IDLE or either FIFO is non-empty.

Function
REQ-015 A push SHALL occur when x_valid && x_ready, and x_ready SHALL equal (x_count < DEPTH), regardless of any same-cycle pop.
REQ-016 Each FIFO SHALL be circular, with pointers wrapping modulo DEPTH; a simultaneous push and pop SHALL leave the count unchanged.
REQ-017 A pushed entry SHALL be visible on cmd_* no earlier than the cycle after the push (1-cycle minimum latency).
REQ-018 An issue SHALL occur when cmd_valid && cmd_ready and SHALL pop the head of the active-direction FIFO.
REQ-019 cmd_valid SHALL stay high until an issue, with cmd_rw and cmd_addr stable while cmd_ready is low.
REQ-020 The block SHALL implement states ARB_IDLE, ARB_READ, ARB_WRITE and ARB_TURN.
REQ-021 cmd_valid SHALL be asserted only in ARB_READ/ARB_WRITE with the matching FIFO non-empty.
REQ-022 A register last_dir SHALL hold the direction of the last issue, and first_done SHALL be set at the first issue after reset.
REQ-023 In ARB_IDLE with both FIFOs non-empty, the block SHALL select last_dir.
REQ-024 In ARB_IDLE with only one FIFO non-empty, the block SHALL select that direction.
REQ-025 From ARB_IDLE, the block SHALL enter ARB_TURN if first_done=1 and the selected direction differs from last_dir; otherwise it SHALL enter the direction state directly.
REQ-026 A batch counter SHALL clear on entering a direction state and SHALL increment on each issue.
REQ-027 In a direction state, the next state SHALL be evaluated each cycle using post-pop counts.
REQ-028 If the current FIFO is empty and the opposite FIFO is non-empty, the block SHALL go to ARB_TURN.
REQ-029 If the batch counter equals MAX_BATCH and the opposite FIFO is non-empty, the block SHALL go to ARB_TURN.
REQ-030 If the batch counter equals MAX_BATCH and the opposite FIFO is empty, the batch counter SHALL clear and the block SHALL stay in the current state.
REQ-031 If both FIFOs are empty, the block SHALL go to ARB_IDLE.
REQ-032 ARB_TURN SHALL last exactly TURN_R2W cycles (read to write) or TURN_W2R cycles (write to read), then enter the opposite direction state.
REQ-033 Arrivals during ARB_TURN SHALL NOT alter the turn target.
REQ-034 After the last old-direction issue at cycle t, the earliest new-direction cmd_valid SHALL be at cycle t+1+TURN_x.
REQ-035 A parameter value of TURN_x=0 SHALL bypass ARB_TURN entirely.

Reset
REQ-036 While reset=1, the block SHALL set state=ARB_IDLE, FIFOs empty, rd_count=wr_count=0, cmd_valid=0, cmd_rw=2'b00, busy=0, last_dir=READ, first_done=0 and batch=0.
REQ-037 Reset asserted mid-operation (any state, including ARB_TURN) SHALL discard all queued requests.
REQ-038 rd_ready=wr_ready=0 while reset=1, and both SHALL be 1 in the first cycle after reset deassertion.

Verification
REQ-039 The bench SHALL cover reset release followed by an idle period -> all outputs at reset values, rd_ready=wr_ready=1, busy=0.
REQ-040 The bench SHALL cover 3 reads pushed back-to-back with cmd_ready=1 -> 3 READ issues on consecutive cycles starting 1 cycle after the first push, then ARB_IDLE and busy=0.
REQ-041 The bench SHALL cover 6 reads and 1 write queued with cmd_ready=1 -> 4 READs, 2 idle cycles, 1 WRITE, 4 idle cycles, 2 READs.
REQ-042 The bench SHALL cover 5 read pushes with cmd_ready=0 -> first 4 accepted, rd_ready=0 on the 5th, rd_count=4; after cmd_ready rises, the 5th is accepted the cycle after the first issue.
REQ-043 The bench SHALL cover cmd_ready held low 3 cycles with cmd_valid=1 -> cmd_rw and cmd_addr unchanged across those cycles, no pop.
REQ-044 The bench SHALL cover reset asserted on the 2nd cycle of a write-to-read ARB_TURN with 2 reads queued -> the next cycle shows ARB_IDLE, counts 0, and no READ is issued.
